// File: rtl/rom_load_ctrl_pkg.sv
// Shared constants for the ROM download controller: region map, region index and FSM states.
package rom_load_ctrl_pkg;

  localparam int NUM_RGN = 5;

  typedef enum logic [2:0] {
    RGN_CPU    = 3'd0,
    RGN_SOUND  = 3'd1,
    RGN_CHAR   = 3'd2,
    RGN_SPRITE = 3'd3,
    RGN_PROM   = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Index 0 is cpu; sizes are 17 bits so the end of a region can be 16'hFFFF+1.
  localparam logic [NUM_RGN-1:0][15:0] RGN_BASE = {
    16'hD000, 16'hB000, 16'h9000, 16'h8000, 16'h0000
  };
  localparam logic [NUM_RGN-1:0][16:0] RGN_SIZE = {
    17'h00240, 17'h02000, 17'h02000, 17'h01000, 17'h08000
  };

  function automatic logic in_region(input logic [15:0] a, input region_e r);
    logic [16:0] lo;
    lo = {1'b0, RGN_BASE[r]};
    return ({1'b0, a} >= lo) && ({1'b0, a} < (lo + RGN_SIZE[r]));
  endfunction

endpackage

// File: rtl/rom_load_ctrl_region_decode.sv
// Combinational address decoder: one-hot region hit and region-relative offset.
module rom_region_decode
  import rom_load_ctrl_pkg::*;
(
  input  logic [15:0]        i_addr,
  output logic [NUM_RGN-1:0] o_hit,
  output logic [15:0]        o_offset
);

  always_comb begin
    o_hit    = '0;
    o_offset = i_addr;
    for (int i = 0; i < NUM_RGN; i++) begin
      if (in_region(i_addr, region_e'(i[2:0]))) begin
        o_hit[i] = 1'b1;
        o_offset = i_addr - RGN_BASE[i];
      end
    end
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download controller: routes download bytes into region writes and sequences core reset.
// Optional feature macro: ROM_CHECKSUM_EN (mod-256 byte checksum with sum_err).
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 4096,
  parameter logic [15:0] EXPECT_BYTES = 16'hD240
`ifdef ROM_CHECKSUM_EN
  ,
  parameter logic [7:0]  EXPECT_SUM   = 8'h00
`endif
) (
  input  logic        clock_12,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        ext_reset,
  output logic [4:0]  rom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        load_done,
  output logic        size_err,
  output logic        addr_err,
  output logic [15:0] byte_count
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [7:0]  checksum,
  output logic        sum_err
`endif
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_e               r_state, w_next;
  logic                 r_dn_prev;
  logic [15:0]          r_hold_cnt;
  logic [4:0]           r_rom_we;
  logic [15:0]          r_rom_addr, r_byte_count;
  logic [7:0]           r_rom_data;
  logic                 r_core_reset, r_load_done, r_size_err, r_addr_err;
  logic [NUM_RGN-1:0]   w_hit;
  logic [15:0]          w_offset;
  logic                 w_dn_rise, w_accept, w_good, w_hold_done;
  logic                 w_load_entry, w_load_exit, w_hold_clr;

  rom_region_decode u_dec (
    .i_addr   (dn_addr),
    .o_hit    (w_hit),
    .o_offset (w_offset)
  );

  // r_dn_prev resets high so a download held across reset is not seen as a new session.
  assign w_dn_rise   = dn_download & ~r_dn_prev;
  assign w_accept    = dn_wr & dn_download & (r_state == ST_LOAD);
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

`ifdef ROM_CHECKSUM_EN
  logic [7:0] r_checksum;
  logic       r_sum_err;
  assign w_good = (r_byte_count == EXPECT_BYTES) && (r_checksum == EXPECT_SUM);
`else
  assign w_good = (r_byte_count == EXPECT_BYTES);
`endif

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_dn_rise) w_next = ST_LOAD;
      ST_LOAD: if (!dn_download) w_next = w_good ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (dn_download)      w_next = ST_LOAD;
        else if (ext_reset)   w_next = ST_HOLD;
        else if (w_hold_done) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (dn_download)    w_next = ST_LOAD;
        else if (ext_reset) w_next = ST_HOLD;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load_entry = (w_next == ST_LOAD) && (r_state != ST_LOAD);
    w_load_exit  = (r_state == ST_LOAD) && !dn_download;
    w_hold_clr   = (w_next == ST_HOLD) && ((r_state != ST_HOLD) || ext_reset);
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_dn_prev    <= 1'b1;
      r_hold_cnt   <= '0;
      r_rom_we     <= '0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
      r_core_reset <= 1'b1;
      r_load_done  <= 1'b0;
      r_size_err   <= 1'b0;
      r_addr_err   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_dn_prev    <= dn_download;
      r_core_reset <= (w_next != ST_RUN);
      r_load_done  <= (w_next == ST_RUN);
      r_rom_we     <= w_accept ? w_hit : 5'b0;
      if (w_accept) begin
        r_rom_addr <= w_offset;
        r_rom_data <= dn_data;
      end
      if (w_hold_clr)                          r_hold_cnt <= '0;
      else if (r_state == ST_HOLD && !w_hold_done) r_hold_cnt <= r_hold_cnt + 16'd1;
      if (w_load_entry) begin
        r_byte_count <= '0;
        r_size_err   <= 1'b0;
        r_addr_err   <= 1'b0;
      end else begin
        if (w_accept && r_byte_count != 16'hFFFF) r_byte_count <= r_byte_count + 16'd1;
        if (w_accept && ~|w_hit)                  r_addr_err   <= 1'b1;
        if (w_load_exit && r_byte_count != EXPECT_BYTES) r_size_err <= 1'b1;
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
      r_sum_err  <= 1'b0;
    end else if (w_load_entry) begin
      r_checksum <= '0;
      r_sum_err  <= 1'b0;
    end else begin
      if (w_accept && |w_hit)                         r_checksum <= r_checksum + dn_data;
      if (w_load_exit && r_checksum != EXPECT_SUM)    r_sum_err  <= 1'b1;
    end
  end
  assign checksum = r_checksum;
  assign sum_err  = r_sum_err;
`endif

  assign rom_we     = r_rom_we;
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign core_reset = r_core_reset;
  assign load_done  = r_load_done;
  assign size_err   = r_size_err;
  assign addr_err   = r_addr_err;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: random download sessions against a region-map reference model.
module tb_rom_load_ctrl;

  localparam int unsigned HOLD   = 4096;
  localparam logic [15:0] EXPECT = 16'hD240;
  localparam logic [7:0]  ESUM   = 8'h01;

  logic        clock_12 = 1'b0, reset = 1'b1;
  logic        dn_download = 1'b0, dn_wr = 1'b0, ext_reset = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic [4:0]  rom_we;
  logic [15:0] rom_addr, byte_count;
  logic [7:0]  rom_data;
  logic        core_reset, load_done, size_err, addr_err;
`ifdef ROM_CHECKSUM_EN
  logic [7:0]  checksum;
  logic        sum_err;
`endif

  always #5 clock_12 = ~clock_12;

  rom_load_ctrl #(
    .HOLD_CYCLES (HOLD),
    .EXPECT_BYTES(EXPECT)
`ifdef ROM_CHECKSUM_EN
    ,.EXPECT_SUM (ESUM)
`endif
  ) dut (
    .clock_12   (clock_12),
    .reset      (reset),
    .dn_download(dn_download),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .ext_reset  (ext_reset),
    .rom_we     (rom_we),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .core_reset (core_reset),
    .load_done  (load_done),
    .size_err   (size_err),
    .addr_err   (addr_err),
    .byte_count (byte_count)
`ifdef ROM_CHECKSUM_EN
    ,.checksum  (checksum),
    .sum_err    (sum_err)
`endif
  );

  typedef struct packed {
    logic [4:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        sb[$];
  int         n_chk = 0, n_fail = 0;
  logic [4:0] seen_we = '0;
  bit         m_loading = 0, m_aerr = 0, m_good = 0;
  int         m_count = 0;
  logic [7:0] m_sum = '0;

  function automatic int rgn_of(input logic [15:0] a);
    if (a < 16'h8000) return 0;
    if (a < 16'h9000) return 1;
    if (a < 16'hB000) return 2;
    if (a < 16'hD000) return 3;
    if (a < 16'hD240) return 4;
    return -1;
  endfunction

  function automatic logic [15:0] base_of(input int r);
    case (r)
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h9000;
      3:       return 16'hB000;
      default: return 16'hD000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock_12) begin : monitor
    wr_t exp_w;
    if (!reset && rom_we != 5'b0) begin
      n_chk++;
      seen_we = seen_we | rom_we;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got we=%b addr=%h data=%h with no write expected",
                 rom_we, rom_addr, rom_data);
      end else begin
        exp_w = sb.pop_front();
        if ({rom_we, rom_addr, rom_data} !== exp_w) begin
          n_fail++;
          $display("FAIL sb_write: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                   rom_we, rom_addr, rom_data, exp_w.we, exp_w.addr, exp_w.data);
        end
      end
    end
  end

  task automatic put_byte(input logic [15:0] a, input logic [7:0] d);
    int r;
    @(negedge clock_12);
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    if (m_loading) begin
      r = rgn_of(a);
      if (m_count < 65535) m_count++;
      if (r < 0) m_aerr = 1;
      else begin
        sb.push_back({5'(1 << r), 16'(a - base_of(r)), d});
        m_sum = m_sum + d;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clock_12);
      dn_wr = 1'b0; ext_reset = 1'b0;
    end
  endtask

  task automatic start_session();
    @(negedge clock_12);
    dn_wr = 1'b0; dn_download = 1'b1;
    m_loading = 1; m_count = 0; m_aerr = 0; m_sum = '0;
  endtask

  // The strobe riding on the falling edge must be dropped, so it is never pushed.
  task automatic end_session(input bit strobe);
    @(negedge clock_12);
    dn_download = 1'b0; dn_wr = strobe; dn_addr = 16'h0010; dn_data = 8'h5A;
    m_loading = 0;
`ifdef ROM_CHECKSUM_EN
    m_good = (m_count == int'(EXPECT)) && (m_sum == ESUM);
`else
    m_good = (m_count == int'(EXPECT));
`endif
  endtask

  // Counts rising edges from the one that sampled the trigger until core_reset is seen low.
  task automatic wait_release(input string name, input int exp_edges);
    int e;
    bit rel;
    e = 0; rel = 0;
    while (!rel && e < exp_edges + 64) begin
      @(posedge clock_12);
      e++;
      @(negedge clock_12);
      ext_reset = 1'b0; dn_wr = 1'b0;
      if (core_reset === 1'b0) rel = 1;
    end
    check(name, e, exp_edges);
    check({name, "_load_done"}, {31'b0, load_done}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_we"},     {27'b0, rom_we}, 32'd0);
    check({tag, "_rom_addr"},   {16'b0, rom_addr}, 32'd0);
    check({tag, "_rom_data"},   {24'b0, rom_data}, 32'd0);
    check({tag, "_core_reset"}, {31'b0, core_reset}, 32'd1);
    check({tag, "_load_done"},  {31'b0, load_done}, 32'd0);
    check({tag, "_size_err"},   {31'b0, size_err}, 32'd0);
    check({tag, "_addr_err"},   {31'b0, addr_err}, 32'd0);
    check({tag, "_byte_count"}, {16'b0, byte_count}, 32'd0);
`ifdef ROM_CHECKSUM_EN
    check({tag, "_checksum"},   {24'b0, checksum}, 32'd0);
    check({tag, "_sum_err"},    {31'b0, sum_err}, 32'd0);
`endif
  endtask

  initial begin
    int hits;
    repeat (3) @(negedge clock_12);
    check_reset_vals("por");
    @(negedge clock_12) reset = 1'b0;

    // ext_reset in IDLE has no effect
    @(negedge clock_12) ext_reset = 1'b1;
    idle_cycles(3);
    check("idle_ext_core_reset", {31'b0, core_reset}, 32'd1);
    check("idle_ext_load_done",  {31'b0, load_done}, 32'd0);

    // short session: 100 bytes including a known char write and an unmapped strobe
    start_session();
    put_byte(16'h9005, 8'hA5);
    put_byte(16'hE000, 8'($urandom));
    for (int i = 0; i < 98; i++) begin
      if ($urandom_range(3) == 0) idle_cycles(1);
      put_byte(16'($urandom), 8'($urandom));
    end
    idle_cycles(1);
    check("s1_byte_count", {16'b0, byte_count}, 32'(m_count));
    check("s1_addr_err",   {31'b0, addr_err}, {31'b0, m_aerr});
    end_session(1'b1);
    idle_cycles(3);
    check("s1_size_err",   {31'b0, size_err}, {31'b0, !m_good});
    check("s1_core_reset", {31'b0, core_reset}, 32'd1);
    check("s1_load_done",  {31'b0, load_done}, 32'd0);
    check("s1_count_kept", {16'b0, byte_count}, 32'd100);
    check("s1_sb_drained", 32'(sb.size()), 32'd0);

    // reset in the middle of a session, download held high across release
    start_session();
    for (int i = 0; i < 5; i++) put_byte(16'($urandom_range(16'h7FFF)), 8'($urandom));
    @(posedge clock_12);
    #2 reset = 1'b1; dn_wr = 1'b0;
    sb.delete(); m_loading = 0;
    #1 check_reset_vals("mid");
    @(negedge clock_12) reset = 1'b0;
    put_byte(16'h0100, 8'h33);
    idle_cycles(3);
    check("rst_no_resume_count", {16'b0, byte_count}, 32'd0);
    check("rst_no_resume_core",  {31'b0, core_reset}, 32'd1);
    @(negedge clock_12) dn_download = 1'b0;
    idle_cycles(2);

    // full sequential load of the whole map
    seen_we = '0;
    start_session();
    for (int a = 0; a < int'(EXPECT); a++) begin
`ifdef ROM_CHECKSUM_EN
      put_byte(16'(a), 8'h00);
`else
      put_byte(16'(a), 8'($urandom));
`endif
    end
    idle_cycles(1);
    check("full_byte_count", {16'b0, byte_count}, 32'(m_count));
    end_session(1'b0);
    if (m_good) begin
      wait_release("full_hold_edges", HOLD + 1);
      check("full_regions_seen", {27'b0, seen_we}, 32'h1F);
      check("full_size_err",     {31'b0, size_err}, 32'd0);
      check("full_addr_err",     {31'b0, addr_err}, 32'd0);
      check("full_sb_drained",   32'(sb.size()), 32'd0);

      // ext_reset from RUN: full hold
      @(negedge clock_12) ext_reset = 1'b1;
      wait_release("ext_hold_edges", HOLD + 1);

      // ext_reset again while the hold counter is at 100
      @(negedge clock_12) ext_reset = 1'b1;
      hits = 0;
      for (int i = 0; i < 101; i++) begin
        @(negedge clock_12);
        ext_reset = 1'b0;
        if (core_reset !== 1'b1) hits++;
      end
      check("ext_mid_hold_core", 32'(hits), 32'd0);
      ext_reset = 1'b1;
      wait_release("ext_restart_edges", HOLD + 1);

      // new session from RUN clears status and re-asserts core reset
      start_session();
      idle_cycles(1);
      check("reload_core_reset", {31'b0, core_reset}, 32'd1);
      check("reload_load_done",  {31'b0, load_done}, 32'd0);
      check("reload_byte_count", {16'b0, byte_count}, 32'd0);
      check("reload_size_err",   {31'b0, size_err}, 32'd0);
      put_byte(16'hD23F, 8'($urandom));
      end_session(1'b0);
      idle_cycles(3);
      check("reload_short_size_err", {31'b0, size_err}, 32'd1);
      check("reload_short_core",     {31'b0, core_reset}, 32'd1);
      check("reload_sb_drained",     32'(sb.size()), 32'd0);
    end else begin
      idle_cycles(3);
      check("bad_load_core_reset", {31'b0, core_reset}, 32'd1);
      check("bad_load_done",       {31'b0, load_done}, 32'd0);
      check("bad_load_size_err",   {31'b0, size_err}, {31'b0, m_count != int'(EXPECT)});
`ifdef ROM_CHECKSUM_EN
      check("bad_load_sum_err",    {31'b0, sum_err}, {31'b0, m_sum != ESUM});
      check("bad_load_checksum",   {24'b0, checksum}, {24'b0, m_sum});
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4096, core-reset hold after a good load, 1..65535.
REQ-002 Parameter EXPECT_BYTES, default 16'hD240, byte count for a complete ROM set.
REQ-003 clock_12  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 dn_download  in  1  download session active.
REQ-006 dn_wr  in  1  one-cycle byte strobe.
REQ-007 dn_addr  in  16  absolute download address.
REQ-008 dn_data  in  8  download byte.
REQ-009 ext_reset  in  1  user/OSD reset request.
REQ-010 rom_we  out  5  one-hot region write enable: [0] cpu, [1] sound, [2] char, [3] sprite, [4] prom.
REQ-011 rom_addr  out  16  region-relative offset.
REQ-012 rom_data  out  8  write byte.
REQ-013 core_reset  out  1  holds the game core in reset.
REQ-014 load_done  out  1  high only in RUN.
REQ-015 size_err  out  1  sticky: last session count != EXPECT_BYTES.
REQ-016 addr_err  out  1  sticky: a strobe hit no region.
REQ-017 byte_count  out  16  accepted strobes this session, saturating at 16'hFFFF.

Function
REQ-018 Region map: cpu 0000-7FFF, sound 8000-8FFF, char 9000-AFFF, sprite B000-CFFF, prom D000-D23F; rom_addr = dn_addr minus region base.
REQ-019 A strobe is accepted only when dn_wr=1 and dn_download=1 in the same cycle.
REQ-020 Write path latency is 1 cycle: rom_we, rom_addr and rom_data are registered and rom_we is high exactly one cycle per accepted in-map strobe.
REQ-021 An accepted strobe outside the map produces rom_we=0, sets addr_err and still increments byte_count.
REQ-022 FSM states are IDLE, LOAD, HOLD and RUN.
REQ-023 IDLE -> LOAD on dn_download=1; LOAD clears byte_count, size_err and addr_err on entry.
REQ-024 LOAD -> HOLD on dn_download falling when byte_count == EXPECT_BYTES; otherwise LOAD -> IDLE with size_err=1.
REQ-025 HOLD counts HOLD_CYCLES cycles, then goes to RUN.
REQ-026 RUN -> LOAD on dn_download=1.
REQ-027 RUN -> HOLD on ext_reset=1, restarting the hold counter.
REQ-028 ext_reset during HOLD restarts the counter; ext_reset in IDLE or LOAD is ignored.
REQ-029 dn_download=1 in HOLD -> LOAD, taking priority over ext_reset.
REQ-030 core_reset = 1 in every state except RUN; it is registered, and deasserts in the first RUN cycle.
REQ-031 A strobe coincident with the dn_download falling edge is rejected.

Reset
REQ-032 Asynchronous reset forces state IDLE, core_reset=1, rom_we=0, rom_addr=0, rom_data=0, load_done=0, size_err=0, addr_err=0, byte_count=0, hold counter=0 and checksum state=0.
REQ-033 Reset asserted mid-LOAD abandons the session; a new session needs a fresh dn_download rise after reset release.

Configuration
REQ-034 With ROM_CHECKSUM_EN defined, the block adds parameter EXPECT_SUM (default 8'h00) and outputs checksum[7:0] and sum_err.
REQ-035 checksum is the mod-256 sum of accepted in-map bytes, cleared on LOAD entry.
REQ-036 sum_err is set at the LOAD exit when checksum != EXPECT_SUM and routes LOAD -> IDLE exactly like size_err.
REQ-037 Without ROM_CHECKSUM_EN, these ports, the parameter and the logic are absent and behaviour is otherwise identical.

Structure
REQ-038 A shared package holds the region base/size constants, the region-index enum and the FSM state enum.
REQ-039 One sub-module, rom_region_decode, is combinational: dn_addr in, one-hot hit and offset out.

Verification
REQ-040 Load exactly 16'hD240 sequential bytes, then drop dn_download -> every rom_we bit fires for its region; HOLD lasts 4096 cycles; then core_reset=0 and load_done=1.
REQ-041 Strobe at dn_addr 16'h9005, data 8'hA5 -> next cycle rom_we=5'b00100, rom_addr=16'h0005, rom_data=8'hA5.
REQ-042 Load 100 bytes and end the session -> IDLE, size_err=1, core_reset stays 1.
REQ-043 Strobe at 16'hE000 -> rom_we=0, addr_err=1, byte_count increments.
REQ-044 Pulse ext_reset in RUN -> core_reset=1 for 4096 cycles, then released; pulse ext_reset again in HOLD at count 100 -> counter restarts.
REQ-045 Assert reset mid-LOAD -> all outputs take their reset values immediately; with ROM_CHECKSUM_EN and EXPECT_SUM=8'h01, a full load of zero bytes -> sum_err=1 and the FSM returns to IDLE.
